rf_cmd_ctrl: RTL and testbench
==============================

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, byte width of the RX, TX and register-file data paths.
- ADDR_WIDTH, 4, register-file address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- RST, in, 1, asynchronous active-high reset.
- RX_P_Data, in, DATA_WIDTH, received byte from the UART RX.
- RX_D_VLD, in, 1, one-cycle strobe marking RX_P_Data valid.
- WrEn, out, 1, register-file write strobe.
- RdEn, out, 1, register-file read strobe.
- Address, out, ADDR_WIDTH, register-file address.
- WrData, out, DATA_WIDTH, register-file write data.
- RdData, in, DATA_WIDTH, register-file read data.
- RdData_Valid, in, 1, RdData qualifier.
- TX_P_Data, out, DATA_WIDTH, byte to the UART TX.
- TX_D_VLD, out, 1, one-cycle TX request.
- TX_Busy, in, 1, TX cannot accept a byte.
- Cmd_Error, out, 1, one-cycle pulse on an aborted command.
REQ-003 The block SHALL use one clock, clk; reset SHALL be RST, asynchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-005 In IDLE, an RX byte equal to CMD_WR (0xAA) SHALL move the FSM to WR_ADDR.
REQ-006 In IDLE, an RX byte equal to CMD_RD (0xBB) SHALL move the FSM to RD_ADDR.
REQ-007 In IDLE, any other RX byte SHALL pulse Cmd_Error for one cycle, and the FSM SHALL stay in IDLE.
REQ-008 In WR_ADDR or RD_ADDR, an RX address byte with any bit at or above ADDR_WIDTH set SHALL pulse Cmd_Error and return the FSM to IDLE with no register-file access.
REQ-009 In WR_ADDR or RD_ADDR, an in-range RX address byte SHALL be latched; Address SHALL hold it until the next command's address byte is accepted.
REQ-010 In WR_DATA, an RX byte SHALL set WrData to that byte and assert WrEn for exactly one cycle, in the cycle after the RX_D_VLD strobe; the FSM SHALL then return to IDLE.
REQ-011 In RD_ADDR, acceptance of an in-range address SHALL assert RdEn for exactly one cycle, in the cycle after the RX_D_VLD strobe, and move the FSM to RD_WAIT.
REQ-012 In RD_WAIT, RdData_Valid SHALL latch RdData into a holding register and move the FSM to TX_SEND.
REQ-013 If RdData_Valid is not seen within RD_TIMEOUT (4) cycles after RdEn, the block SHALL pulse Cmd_Error and return to IDLE.
REQ-014 In TX_SEND with TX_Busy low, TX_D_VLD SHALL pulse for one cycle with TX_P_Data equal to the held byte, and the FSM SHALL return to IDLE.
REQ-015 In TX_SEND with TX_Busy high, the block SHALL wait with TX_D_VLD low; there SHALL be no timeout.
REQ-016 WrEn and RdEn SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per command.
REQ-017 RX_D_VLD strobes arriving in RD_WAIT or TX_SEND SHALL be discarded, with no error.
REQ-018 RdData_Valid outside RD_WAIT SHALL be ignored.
REQ-019 Write latency SHALL be one cycle (data strobe to WrEn); read latency SHALL be one cycle (address strobe to RdEn), then one cycle after RdData_Valid to TX_D_VLD if TX_Busy is low.
REQ-020 All outputs SHALL be driven from registers.

Reset
REQ-021 While RST is high, the FSM SHALL be in IDLE, and WrEn, RdEn, TX_D_VLD, Cmd_Error, Address, WrData, TX_P_Data, the holding register and the timeout counter SHALL all be 0.
REQ-022 RST asserted mid-command SHALL abort it immediately, with no pending strobe issued after release; the first RX byte after release SHALL be decoded as a command.

Structure
REQ-023 Package rf_ctrl_pkg SHALL hold CMD_WR, CMD_RD, RD_TIMEOUT and the FSM state type.
REQ-024 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- RX 0xAA, 0x05, 0x3C -> exactly one WrEn, Address=5, WrData=0x3C, one cycle after the third strobe; Cmd_Error stays 0.
- RX 0xBB, 0x02; RdData_Valid one cycle after RdEn with RdData=0x21 -> TX_D_VLD one cycle later with TX_P_Data=0x21.
- Same read with TX_Busy high for 10 cycles -> TX_D_VLD held low, then a single pulse with 0x21 in the cycle after TX_Busy falls.
- RX 0x77; then RX 0xAA, 0x1F -> two Cmd_Error pulses, no WrEn, FSM in IDLE.
- RX 0xBB, 0x03 with RdData_Valid never asserted -> Cmd_Error 4 cycles after RdEn, no TX_D_VLD.
- RX 0xAA, 0x04, then RST pulsed, then RX 0x99 -> no WrEn, all outputs 0 during reset, 0x99 decoded as a command (Cmd_Error pulse).

Source files
------------

// File: rtl/rf_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_ctrl_pkg
// Brief    : Command bytes, read timeout and FSM state type for rf_cmd_ctrl.
// Revision : 1.0
// ============================================================================
package rf_ctrl_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam int         RD_TIMEOUT = 4;
    localparam int         TMO_W      = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_cmd_ctrl_if
// Brief    : UART RX/TX and register-file bundle around rf_cmd_ctrl.
// Revision : 1.0
// ============================================================================
interface rf_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();

    logic [DATA_WIDTH-1:0] RX_P_Data;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;
    logic [DATA_WIDTH-1:0] TX_P_Data;
    logic                  TX_D_VLD;
    logic                  TX_Busy;
    logic                  Cmd_Error;

    // master is the controller, slave is the UART/register-file side
    modport master (
        input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
        output WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Error
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
        input  WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Error
    );

endinterface
`default_nettype wire

// File: rtl/rf_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_cmd_ctrl
// Brief    : Decodes UART command bytes into register-file writes and reads;
//            read data is returned to the UART TX.
// Revision : 1.0
// ============================================================================
module rf_cmd_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     RST,
    rf_cmd_ctrl_if.master bus
);

    state_t                r_state,    w_state_nxt;
    logic                  r_wr_en,    w_wr_en_nxt;
    logic                  r_rd_en,    w_rd_en_nxt;
    logic                  r_tx_vld,   w_tx_vld_nxt;
    logic                  r_cmd_err,  w_cmd_err_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data,  w_tx_data_nxt;
    logic [DATA_WIDTH-1:0] r_hold,     w_hold_nxt;
    logic [TMO_W-1:0]      r_tmo_cnt,  w_tmo_cnt_nxt;

    logic                  w_addr_oob;

    // Any set bit above the register-file address range rejects the byte
    assign w_addr_oob = |(bus.RX_P_Data >> ADDR_WIDTH);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tx_data <= '0;
            r_hold    <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_hold    <= w_hold_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_tx_vld_nxt  = 1'b0;
        w_cmd_err_nxt = 1'b0;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_tx_data_nxt = r_tx_data;
        w_hold_nxt    = r_hold;
        w_tmo_cnt_nxt = r_tmo_cnt;

        unique case (r_state)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_Data == DATA_WIDTH'(CMD_WR)) begin
                        w_state_nxt = WR_ADDR;
                    end else if (bus.RX_P_Data == DATA_WIDTH'(CMD_RD)) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (w_addr_oob) begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_addr_nxt  = bus.RX_P_Data[ADDR_WIDTH-1:0];
                        w_state_nxt = WR_DATA;
                    end
                end
            end

            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    w_wdata_nxt = bus.RX_P_Data;
                    w_wr_en_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (w_addr_oob) begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_addr_nxt    = bus.RX_P_Data[ADDR_WIDTH-1:0];
                        w_rd_en_nxt   = 1'b1;
                        w_tmo_cnt_nxt = '0;
                        w_state_nxt   = RD_WAIT;
                    end
                end
            end

            // An idle TX takes the byte straight away, keeping read-to-TX latency at one cycle
            RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    w_hold_nxt    = bus.RdData;
                    w_tmo_cnt_nxt = '0;
                    if (!bus.TX_Busy) begin
                        w_tx_vld_nxt  = 1'b1;
                        w_tx_data_nxt = bus.RdData;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_state_nxt = TX_SEND;
                    end
                end else if (r_tmo_cnt == TMO_W'(RD_TIMEOUT - 1)) begin
                    w_cmd_err_nxt = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end

            TX_SEND: begin
                if (!bus.TX_Busy) begin
                    w_tx_vld_nxt  = 1'b1;
                    w_tx_data_nxt = r_hold;
                    w_state_nxt   = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.WrEn      = r_wr_en;
    assign bus.RdEn      = r_rd_en;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.Cmd_Error = r_cmd_err;
    assign bus.Address   = r_addr;
    assign bus.WrData    = r_wdata;
    assign bus.TX_P_Data = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_cmd_ctrl
// Brief    : Directed self-checking bench for rf_cmd_ctrl.
// Revision : 1.0
// ============================================================================
module tb_rf_cmd_ctrl;

    logic clk;
    logic RST;

    int checks   = 0;
    int failures = 0;

    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int tx_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    int wr0, rd0, tx0, err0;

    rf_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    rf_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!RST) begin
            if (bus.WrEn)              wr_cnt++;
            if (bus.RdEn)              rd_cnt++;
            if (bus.TX_D_VLD)          tx_cnt++;
            if (bus.Cmd_Error)         err_cnt++;
            if (bus.WrEn && bus.RdEn)  both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic snap();
        wr0  = wr_cnt;
        rd0  = rd_cnt;
        tx0  = tx_cnt;
        err0 = err_cnt;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"},   {31'd0, bus.WrEn},      32'd0);
        chk({tag, "_rden"},   {31'd0, bus.RdEn},      32'd0);
        chk({tag, "_txvld"},  {31'd0, bus.TX_D_VLD},  32'd0);
        chk({tag, "_err"},    {31'd0, bus.Cmd_Error}, 32'd0);
        chk({tag, "_addr"},   {28'd0, bus.Address},   32'd0);
        chk({tag, "_wdata"},  {24'd0, bus.WrData},    32'd0);
        chk({tag, "_txdata"}, {24'd0, bus.TX_P_Data}, 32'd0);
    endtask

    initial begin
        RST              = 1'b1;
        bus.RX_P_Data    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.TX_Busy      = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk_outputs_zero("reset");
        RST = 1'b0;
        tick();

        // ---- write 0x3C to address 5 ----
        snap();
        send_byte(8'hAA);
        chk("wr_cmd_no_wren", {31'd0, bus.WrEn}, 32'd0);
        tick();
        send_byte(8'h05);
        chk("wr_addr_no_wren", {31'd0, bus.WrEn}, 32'd0);
        tick();
        send_byte(8'h3C);
        chk("wr_wren",  {31'd0, bus.WrEn},    32'd1);
        chk("wr_addr",  {28'd0, bus.Address}, 32'd5);
        chk("wr_wdata", {24'd0, bus.WrData},  32'h3C);
        chk("wr_rden",  {31'd0, bus.RdEn},    32'd0);
        tick();
        chk("wr_wren_drop", {31'd0, bus.WrEn}, 32'd0);
        tick();
        chk("wr_wren_count", wr_cnt - wr0,  32'd1);
        chk("wr_err_count",  err_cnt - err0, 32'd0);

        // ---- read address 2, data 0x21, TX idle ----
        snap();
        send_byte(8'hBB);
        tick();
        send_byte(8'h02);
        chk("rd_rden", {31'd0, bus.RdEn},    32'd1);
        chk("rd_addr", {28'd0, bus.Address}, 32'd2);
        tick();
        chk("rd_rden_drop", {31'd0, bus.RdEn}, 32'd0);
        bus.RdData       = 8'h21;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        chk("rd_txvld",  {31'd0, bus.TX_D_VLD},  32'd1);
        chk("rd_txdata", {24'd0, bus.TX_P_Data}, 32'h21);
        tick();
        chk("rd_txvld_drop", {31'd0, bus.TX_D_VLD}, 32'd0);
        chk("rd_rd_count", rd_cnt - rd0, 32'd1);
        chk("rd_tx_count", tx_cnt - tx0, 32'd1);

        // ---- same read with TX busy for 10 cycles ----
        snap();
        bus.RdData = 8'h00;
        send_byte(8'hBB);
        tick();
        send_byte(8'h02);
        chk("busy_rden", {31'd0, bus.RdEn}, 32'd1);
        tick();
        bus.RdData       = 8'h21;
        bus.RdData_Valid = 1'b1;
        bus.TX_Busy      = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        bus.RdData       = 8'h00;
        for (int i = 0; i < 9; i++) begin
            chk("busy_txvld_low", {31'd0, bus.TX_D_VLD}, 32'd0);
            tick();
        end
        chk("busy_txvld_low_end", {31'd0, bus.TX_D_VLD}, 32'd0);
        bus.TX_Busy = 1'b0;
        tick();
        chk("busy_txvld",  {31'd0, bus.TX_D_VLD},  32'd1);
        chk("busy_txdata", {24'd0, bus.TX_P_Data}, 32'h21);
        tick();
        chk("busy_txvld_drop", {31'd0, bus.TX_D_VLD}, 32'd0);
        chk("busy_tx_count", tx_cnt - tx0, 32'd1);

        // ---- bad command, then out-of-range address ----
        snap();
        send_byte(8'h77);
        chk("badcmd_err", {31'd0, bus.Cmd_Error}, 32'd1);
        tick();
        chk("badcmd_err_drop", {31'd0, bus.Cmd_Error}, 32'd0);
        send_byte(8'hAA);
        tick();
        send_byte(8'h1F);
        chk("oob_err",  {31'd0, bus.Cmd_Error}, 32'd1);
        chk("oob_wren", {31'd0, bus.WrEn},      32'd0);
        chk("oob_addr_kept", {28'd0, bus.Address}, 32'd2);
        tick();
        chk("oob_err_count", err_cnt - err0, 32'd2);
        // a fresh non-command byte must be decoded in IDLE, not taken as write data
        send_byte(8'h55);
        chk("oob_idle_err",  {31'd0, bus.Cmd_Error}, 32'd1);
        chk("oob_idle_wren", {31'd0, bus.WrEn},      32'd0);
        tick();
        chk("oob_wr_count", wr_cnt - wr0, 32'd0);

        // ---- highest legal address ----
        snap();
        send_byte(8'hAA);
        tick();
        send_byte(8'h0F);
        chk("maxaddr_err", {31'd0, bus.Cmd_Error}, 32'd0);
        tick();
        send_byte(8'h81);
        chk("maxaddr_wren",  {31'd0, bus.WrEn},    32'd1);
        chk("maxaddr_addr",  {28'd0, bus.Address}, 32'hF);
        chk("maxaddr_wdata", {24'd0, bus.WrData},  32'h81);
        tick();

        // ---- read timeout, with a stray RX strobe in RD_WAIT ----
        snap();
        send_byte(8'hBB);
        tick();
        send_byte(8'h03);
        chk("tmo_rden", {31'd0, bus.RdEn}, 32'd1);
        tick();
        chk("tmo_err_c1", {31'd0, bus.Cmd_Error}, 32'd0);
        send_byte(8'h77);
        chk("tmo_err_c2", {31'd0, bus.Cmd_Error}, 32'd0);
        tick();
        chk("tmo_err_c3", {31'd0, bus.Cmd_Error}, 32'd0);
        tick();
        chk("tmo_err_c4", {31'd0, bus.Cmd_Error}, 32'd1);
        tick();
        chk("tmo_err_drop", {31'd0, bus.Cmd_Error}, 32'd0);
        tick();
        chk("tmo_tx_count",  tx_cnt - tx0,   32'd0);
        chk("tmo_err_count", err_cnt - err0, 32'd1);

        // ---- reset in the middle of a write ----
        snap();
        send_byte(8'hAA);
        tick();
        send_byte(8'h04);
        chk("rst_addr_latched", {28'd0, bus.Address}, 32'd4);
        tick();
        RST = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        tick();
        tick();
        RST = 1'b0;
        tick();
        send_byte(8'h99);
        chk("rst_99_err",  {31'd0, bus.Cmd_Error}, 32'd1);
        chk("rst_99_wren", {31'd0, bus.WrEn},      32'd0);
        tick();
        tick();
        chk("rst_wr_count", wr_cnt - wr0, 32'd0);

        chk("never_both_strobes", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
